// File: rtl/dmem_pkg.sv
// -----------------------------------------------------------------------------
// Module      : dmem_pkg
// Description : Shared memory geometry for dmem, imem and the gold_cmp top.
// Revision    : 1.0 - initial release
// -----------------------------------------------------------------------------
`default_nettype none

package dmem_pkg;

    localparam int DMEM_ADDR_W = 8;
    localparam int DMEM_DATA_W = 64;
    localparam int DMEM_DEPTH  = 256;

    // imem shares the address space but carries 32-bit instruction words
    localparam int IMEM_ADDR_W = 8;
    localparam int IMEM_DATA_W = 32;

    typedef logic [0:DMEM_ADDR_W-1] dmem_addr_t;
    typedef logic [0:DMEM_DATA_W-1] dmem_word_t;

endpackage : dmem_pkg

`default_nettype wire

// File: rtl/dmem.sv
// -----------------------------------------------------------------------------
// Module      : dmem
// Description : 256 x 64 single-port data memory with a registered read port.
// Revision    : 1.0 - initial release
// -----------------------------------------------------------------------------
`default_nettype none

module dmem
    import dmem_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   memEn,
    input  logic                   memWrEn,
    input  logic [0:DMEM_ADDR_W-1] memAddr,
    input  logic [0:DMEM_DATA_W-1] dataIn,
    output logic [0:DMEM_DATA_W-1] dataOut
);

    // Left unreset and unnamed-wrapped so testbenches can preload and peek it.
    logic [0:DMEM_DATA_W-1] MEM [0:DMEM_DEPTH-1];

    logic [0:DMEM_DATA_W-1] data_out_q;

    // Reset clears only the read register; the array keeps its contents.
    always_ff @(posedge clk) begin
        if (reset) begin
            data_out_q <= '0;
        end else if (memEn) begin
            if (memWrEn) begin
                MEM[memAddr] <= dataIn;
            end else begin
                data_out_q <= MEM[memAddr];
            end
        end
    end

    assign dataOut = data_out_q;

endmodule : dmem

`default_nettype wire

// File: tb/tb_dmem.sv
// -----------------------------------------------------------------------------
// Module      : tb_dmem
// Description : Directed plus randomized checking of dmem against a word model.
// Revision    : 1.0 - initial release
// -----------------------------------------------------------------------------
`default_nettype none

module tb_dmem;

    logic        clk;
    logic        reset;
    logic        memEn;
    logic        memWrEn;
    logic [0:7]  memAddr;
    logic [0:63] dataIn;
    logic [0:63] dataOut;

    int n_tests;
    int n_fail;

    // Reference: plain word array, a written/loaded flag per word, expected output
    logic [63:0] mdl [256];
    bit          vld [256];
    logic [63:0] exp_out;
    bit          exp_known;

    dmem DM0 (
        .clk     (clk),
        .reset   (reset),
        .memEn   (memEn),
        .memWrEn (memWrEn),
        .memAddr (memAddr),
        .dataIn  (dataIn),
        .dataOut (dataOut)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One clock: apply inputs, advance the model, compare dataOut after the edge.
    task automatic cycle(input bit rst, input bit en, input bit we,
                         input int addr, input logic [63:0] data);
        reset   = rst;
        memEn   = en;
        memWrEn = we;
        memAddr = addr[7:0];
        dataIn  = data;
        @(posedge clk);
        if (rst) begin
            exp_out   = 64'h0;
            exp_known = 1'b1;
        end else if (en && we) begin
            mdl[addr] = data;
            vld[addr] = 1'b1;
        end else if (en) begin
            exp_out   = mdl[addr];
            exp_known = vld[addr];
        end
        #1;
        if (exp_known) check("dout", dataOut, exp_out);
    endtask

    logic [63:0] word;
    logic [63:0] prior3;

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        exp_known = 1'b0;
        exp_out   = 64'h0;
        for (int i = 0; i < 256; i++) vld[i] = 1'b0;
        reset   = 1'b1;
        memEn   = 1'b0;
        memWrEn = 1'b0;
        memAddr = '0;
        dataIn  = '0;

        // Preload before the first clock edge
        DM0.MEM[5] = 64'h0123456789ABCDEF; mdl[5] = 64'h0123456789ABCDEF; vld[5] = 1'b1;
        DM0.MEM[0] = 64'h1;                mdl[0] = 64'h1;                vld[0] = 1'b1;
        DM0.MEM[1] = 64'h2;                mdl[1] = 64'h2;                vld[1] = 1'b1;
        DM0.MEM[2] = 64'h3;                mdl[2] = 64'h3;                vld[2] = 1'b1;

        // Reset held 5 cycles with access requests that must be ignored
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, 1'b1, (i % 2) == 1, 5, 64'hFFFF_FFFF_FFFF_FFFF);
            check("reset_zero", dataOut, 64'h0);
        end

        cycle(1'b0, 1'b1, 1'b0, 5, 64'h0);
        check("preload_read5", dataOut, 64'h0123456789ABCDEF);

        // Write to top address: output holds, then read returns new data
        cycle(1'b0, 1'b1, 1'b1, 255, 64'hDEADBEEFCAFEF00D);
        check("hold_on_write", dataOut, 64'h0123456789ABCDEF);
        cycle(1'b0, 1'b1, 1'b0, 255, 64'h0);
        check("raw_255", dataOut, 64'hDEADBEEFCAFEF00D);

        // Disabled write must not touch addr 3
        prior3 = 64'h3333_4444_5555_6666;
        cycle(1'b0, 1'b1, 1'b1, 3, prior3);
        cycle(1'b0, 1'b0, 1'b1, 3, 64'hFFFF_FFFF_FFFF_FFFF);
        check("idle_hold", dataOut, 64'hDEADBEEFCAFEF00D);
        cycle(1'b0, 1'b1, 1'b0, 3, 64'h0);
        check("no_write_when_off", dataOut, prior3);

        // Back-to-back reads without bubbles
        cycle(1'b0, 1'b1, 1'b0, 0, 64'h0);
        check("b2b_0", dataOut, 64'h1);
        cycle(1'b0, 1'b1, 1'b0, 1, 64'h0);
        check("b2b_1", dataOut, 64'h2);
        cycle(1'b0, 1'b1, 1'b0, 2, 64'h0);
        check("b2b_2", dataOut, 64'h3);

        // Memory survives reset; first access after reset completes
        cycle(1'b0, 1'b1, 1'b1, 10, 64'hA5A5A5A5A5A5A5A5);
        cycle(1'b1, 1'b0, 1'b0, 10, 64'h0);
        check("mid_reset0", dataOut, 64'h0);
        cycle(1'b1, 1'b1, 1'b0, 10, 64'h0);
        check("mid_reset1", dataOut, 64'h0);
        cycle(1'b0, 1'b1, 1'b0, 10, 64'h0);
        check("retained_10", dataOut, 64'hA5A5A5A5A5A5A5A5);

        // Fill every word through the port so random reads are all defined
        for (int a = 0; a < 256; a++) begin
            word = {$urandom, $urandom};
            cycle(1'b0, 1'b1, 1'b1, a, word);
        end

        // Randomized traffic, occasional reset
        for (int i = 0; i < 3000; i++) begin
            word = {$urandom, $urandom};
            cycle(($urandom_range(0, 63) == 0), ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 2) == 0), $urandom_range(0, 255), word);
        end

        // Word-for-word dump of the lower half against the model
        for (int i = 0; i < 128; i++) begin
            word = DM0.MEM[i];
            check($sformatf("dump[%0d]", i), word, mdl[i]);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Watchdog
    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule : tb_dmem

`default_nettype wire

// File: doc/dmem.md
DMEM -- requirements
Module: dmem

Interface
REQ-001 Parameters: none; widths and depth come from the shared package (REQ-021).
REQ-002 clk  input  1  system clock; all state changes on the rising edge.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 memEn  input  1  access enable; no access occurs when low.
REQ-005 memWrEn  input  1  write select; 1 = write, 0 = read; ignored when memEn = 0.
REQ-006 memAddr  input  [0:7]  word address, bit 0 = MSB; selects one of 256 words.
REQ-007 dataIn  input  [0:63]  write data, bit 0 = MSB.
REQ-008 dataOut  output  [0:63]  registered read data, bit 0 = MSB.

Function
REQ-009 Storage: one array named MEM, 256 words x 64 bits, declared [0:63] MEM[0:255]. Hierarchical $readmemh preload and per-index peek (for example DM0.MEM[i]) shall work without any wrapper.
REQ-010 Write: on a rising edge with reset = 0, memEn = 1 and memWrEn = 1, MEM[memAddr] <= dataIn; dataOut holds its previous value.
REQ-011 Read: on a rising edge with reset = 0, memEn = 1 and memWrEn = 0, dataOut <= MEM[memAddr]; read latency is exactly 1 cycle.
REQ-012 Idle: memEn = 0 means no array change and dataOut holds.
REQ-013 Read-after-write, same address, next cycle: the read returns the newly written data.
REQ-014 Back-to-back reads on consecutive cycles return one word per cycle with no bubbles.
REQ-015 Addresses 0..255 are all valid; there is no wrap, alias or out-of-range case.
REQ-016 Only one access per cycle; there is no byte or partial-word write, and all 64 bits are always written.
REQ-017 Contents that were never written or loaded read as X in simulation; there is no implicit zero-fill.

Reset
REQ-018 While reset = 1 at a rising edge, dataOut <= 64'h0, and read and write requests are ignored.
REQ-019 Reset shall not modify MEM, so contents preloaded before or during reset survive.
REQ-020 Reset asserted mid-stream aborts any pending read result (dataOut becomes 0). The first access after reset deasserts completes normally.

Structure
REQ-021 Shared package: DMEM_ADDR_W = 8, DMEM_DATA_W = 64, DMEM_DEPTH = 256. These are shared with imem (32-bit data, 8-bit address) and with the gold_cmp top level.
REQ-022 No sub-module: one flat always block for the array and the output register. The array shall be inferable as a single-port synchronous RAM.
REQ-023 The design is instantiated once per CMP node (four instances). The node's address_out[24:31] drives memAddr, and the node's d_out/d_in connect to dataIn/dataOut.

Verification
REQ-024 Preload MEM[5] = 64'h0123456789ABCDEF before reset; hold reset 5 cycles; read addr 5 -> dataOut = 64'h0123456789ABCDEF one cycle after the request edge, and dataOut = 0 throughout reset.
REQ-025 Write 64'hDEADBEEFCAFEF00D to addr 255, then read addr 255 next cycle -> dataOut = 64'hDEADBEEFCAFEF00D; the dataOut value during the write cycle is unchanged.
REQ-026 memEn = 0 with memWrEn = 1 and addr 3, data 64'hFFFF... -> MEM[3] is unchanged (a subsequent read returns its prior value).
REQ-027 Reads of addrs 0,1,2 on three consecutive cycles, preloaded 64'h1, 64'h2, 64'h3 -> dataOut sequence 1, 2, 3 with 1-cycle latency and no gaps.
REQ-028 Write addr 10 = 64'hA5A5..., then assert reset 2 cycles, then read addr 10 -> dataOut = 0 during reset, then 64'hA5A5... afterwards (memory retained).
REQ-029 Dump loop over MEM[0..127] after a run -> file matches the expected golden dump word-for-word.
